dffram_nibble_host: RTL and testbench

- Host-side initiator that drives the pins of the 2R1W nibble-wide DFF RAM tile from a byte-wide request/response interface.
- Converts each byte write into two nibble write cycles on port A, and each byte read into two nibble read cycles on port A, plus port B for dual reads.
- Runs the tile's configuration-at-reset sequence on startup and whenever the address bank bit changes.
- Instantiated in the test harness/carrier next to the tile; both share one clock.

---
 rtl/dffram_nibble_host_if.sv | 37 +++
 rtl/dffram_nibble_host.sv | 190 +++++++++++++++++++
 tb/tb_dffram_nibble_host.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dffram_nibble_host_if.sv
// Byte-wide request/response bundle between a host client and dffram_nibble_host.
// Requests are accepted on req_valid & req_ready; rsp_valid is a single-cycle pulse.
interface dffram_nibble_host_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [4:0] req_addr;
    logic [3:0] req_addr_b;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_data_a;
    logic [7:0] rsp_data_b;

    modport master (
        output req_valid,
        output req_op,
        output req_addr,
        output req_addr_b,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data_a,
        input  rsp_data_b
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_addr,
        input  req_addr_b,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_data_a,
        output rsp_data_b
    );
endinterface

// File: rtl/dffram_nibble_host.sv
// Drives the 2R1W nibble DFF RAM tile pins from byte requests, splitting each
// byte into two nibble cycles and replaying the tile's reset-time config latch.
module dffram_nibble_host #(
    parameter bit RD_BUF     = 1'b0,
    parameter int CFG_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    dffram_nibble_host_if.slave bus,
    output logic                ram_rst_n,
    output logic [7:0]          ram_ui_in,
    output logic [7:0]          ram_uio_in,
    input  logic [7:0]          ram_uo_out
);
    localparam int CW = (CFG_CYCLES > 1) ? $clog2(CFG_CYCLES) : 1;
    localparam logic [CW-1:0] CFG_LAST = CW'(CFG_CYCLES - 1);

    typedef enum logic [3:0] {
        S_CFG,
        S_CFG_REL,
        S_IDLE,
        S_WR_LO,
        S_WR_HI,
        S_RD_LO,
        S_RD_HI,
        S_RD_TAIL,
        S_RSP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          bank, bank_n;
    logic          pend, pend_n;
    logic          wr, wr_n;
    logic          dual, dual_n;
    logic [3:0]    addr, addr_n;
    logic [3:0]    addr_b, addr_b_n;
    logic [7:0]    wdata, wdata_n;
    logic [3:0]    lo_a, lo_a_n;
    logic [3:0]    lo_b, lo_b_n;
    logic          rst_o, ready_o, valid_o;
    logic [7:0]    ui_o, uio_o, da_n, db_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_CFG;
            cnt            <= '0;
            bank           <= 1'b0;
            pend           <= 1'b0;
            wr             <= 1'b0;
            dual           <= 1'b0;
            addr           <= 4'h0;
            addr_b         <= 4'h0;
            wdata          <= 8'h00;
            lo_a           <= 4'h0;
            lo_b           <= 4'h0;
            ram_rst_n      <= 1'b0;
            ram_ui_in      <= 8'h00;
            ram_uio_in     <= {2'b00, RD_BUF, RD_BUF, 4'h0};
            bus.req_ready  <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_data_a <= 8'h00;
            bus.rsp_data_b <= 8'h00;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            bank           <= bank_n;
            pend           <= pend_n;
            wr             <= wr_n;
            dual           <= dual_n;
            addr           <= addr_n;
            addr_b         <= addr_b_n;
            wdata          <= wdata_n;
            lo_a           <= lo_a_n;
            lo_b           <= lo_b_n;
            ram_rst_n      <= rst_o;
            ram_ui_in      <= ui_o;
            ram_uio_in     <= uio_o;
            bus.req_ready  <= ready_o;
            bus.rsp_valid  <= valid_o;
            bus.rsp_data_a <= da_n;
            bus.rsp_data_b <= db_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bank_n   = bank;
        pend_n   = pend;
        wr_n     = wr;
        dual_n   = dual;
        addr_n   = addr;
        addr_b_n = addr_b;
        wdata_n  = wdata;
        lo_a_n   = lo_a;
        lo_b_n   = lo_b;
        da_n     = 8'h00;
        db_n     = 8'h00;
        unique case (state)
            S_CFG: begin
                if (cnt == CFG_LAST) state_n = S_CFG_REL;
                else cnt_n = cnt + 1'b1;
            end
            S_CFG_REL: begin
                pend_n  = 1'b0;
                if (!pend) state_n = S_IDLE;
                else state_n = wr ? S_WR_LO : S_RD_LO;
            end
            S_IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    wr_n     = (bus.req_op == 2'b00);
                    dual_n   = (bus.req_op == 2'b10);
                    addr_n   = bus.req_addr[3:0];
                    addr_b_n = dual_n ? bus.req_addr_b : 4'h0;
                    wdata_n  = bus.req_wdata;
                    // A bank change must re-run the tile's config latch first.
                    if (bus.req_addr[4] != bank) begin
                        bank_n  = bus.req_addr[4];
                        cnt_n   = '0;
                        pend_n  = 1'b1;
                        state_n = S_CFG;
                    end else begin
                        state_n = wr_n ? S_WR_LO : S_RD_LO;
                    end
                end
            end
            S_WR_LO: state_n = S_WR_HI;
            S_WR_HI: state_n = S_RSP;
            S_RD_LO: begin
                state_n = S_RD_HI;
                if (!RD_BUF) begin
                    lo_a_n = ram_uo_out[3:0];
                    lo_b_n = ram_uo_out[7:4];
                end
            end
            S_RD_HI: begin
                if (RD_BUF) begin
                    lo_a_n  = ram_uo_out[3:0];
                    lo_b_n  = ram_uo_out[7:4];
                    state_n = S_RD_TAIL;
                end else begin
                    da_n    = {ram_uo_out[3:0], lo_a};
                    db_n    = dual ? {ram_uo_out[7:4], lo_b} : 8'h00;
                    state_n = S_RSP;
                end
            end
            S_RD_TAIL: begin
                da_n    = {ram_uo_out[3:0], lo_a};
                db_n    = dual ? {ram_uo_out[7:4], lo_b} : 8'h00;
                state_n = S_RSP;
            end
            S_RSP: state_n = S_IDLE;
            default: state_n = S_CFG;
        endcase

        // Pins are registered, so decode them from the state being entered.
        rst_o   = 1'b1;
        ready_o = 1'b0;
        valid_o = 1'b0;
        ui_o    = 8'h00;
        uio_o   = 8'h00;
        unique case (state_n)
            S_CFG: begin
                rst_o = 1'b0;
                uio_o = {2'b00, RD_BUF, RD_BUF, 3'b000, bank_n};
            end
            S_CFG_REL: uio_o = {2'b00, RD_BUF, RD_BUF, 3'b000, bank_n};
            S_IDLE:    ready_o = 1'b1;
            S_WR_LO: begin
                ui_o  = {addr_n, wdata_n[3:0]};
                uio_o = 8'h90;
            end
            S_WR_HI: begin
                ui_o  = {addr_n, wdata_n[7:4]};
                uio_o = 8'h80;
            end
            S_RD_LO: begin
                ui_o  = {addr_n, 4'h0};
                uio_o = {4'h0, addr_b_n};
            end
            S_RD_HI, S_RD_TAIL: begin
                ui_o  = {addr_n, 4'h0};
                uio_o = {4'b0011, addr_b_n};
            end
            S_RSP:   valid_o = 1'b1;
            default: rst_o = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_dffram_nibble_host.sv
// Bench for dffram_nibble_host: RD_BUF=0 and RD_BUF=1 hosts run side by side,
// each driving a behavioural nibble tile, checked against a byte-level model.
module tb_dffram_nibble_host;
    localparam int CFG = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       req_valid = 1'b0;
    logic [1:0] req_op = 2'b00;
    logic [4:0] req_addr = 5'h00;
    logic [3:0] req_addr_b = 4'h0;
    logic [7:0] req_wdata = 8'h00;

    dffram_nibble_host_if bus0 ();
    dffram_nibble_host_if bus1 ();

    assign bus0.req_valid  = req_valid;
    assign bus0.req_op     = req_op;
    assign bus0.req_addr   = req_addr;
    assign bus0.req_addr_b = req_addr_b;
    assign bus0.req_wdata  = req_wdata;
    assign bus1.req_valid  = req_valid;
    assign bus1.req_op     = req_op;
    assign bus1.req_addr   = req_addr;
    assign bus1.req_addr_b = req_addr_b;
    assign bus1.req_wdata  = req_wdata;

    logic [1:0]      rdy, rv, rrst;
    logic [1:0][7:0] da, db, ui, uio, uo;

    assign rdy[0] = bus0.req_ready;
    assign rdy[1] = bus1.req_ready;
    assign rv[0]  = bus0.rsp_valid;
    assign rv[1]  = bus1.rsp_valid;
    assign da[0]  = bus0.rsp_data_a;
    assign da[1]  = bus1.rsp_data_a;
    assign db[0]  = bus0.rsp_data_b;
    assign db[1]  = bus1.rsp_data_b;

    dffram_nibble_host #(.RD_BUF(1'b0), .CFG_CYCLES(CFG)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .ram_rst_n(rrst[0]),
        .ram_ui_in(ui[0]), .ram_uio_in(uio[0]), .ram_uo_out(uo[0]));

    dffram_nibble_host #(.RD_BUF(1'b1), .CFG_CYCLES(CFG)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .ram_rst_n(rrst[1]),
        .ram_ui_in(ui[1]), .ram_uio_in(uio[1]), .ram_uo_out(uo[1]));

    // Tile holds 18 bytes; bank-1 addresses 18..31 alias to byte 0.
    function automatic int eff(input logic [4:0] f);
        return (f > 5'd17) ? 0 : int'(f);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : tile
        logic [7:0] mem [0:17];
        logic       tbank = 1'b0;
        logic       tbuf = 1'b0;
        logic [7:0] comb;
        logic [7:0] regd = 8'h00;
        initial for (int i = 0; i < 18; i++) mem[i] = 8'h00;
        always_comb begin
            comb = 8'h00;
            comb[3:0] = uio[g][4] ? mem[eff({tbank, ui[g][7:4]})][7:4]
                                  : mem[eff({tbank, ui[g][7:4]})][3:0];
            comb[7:4] = uio[g][5] ? mem[eff({tbank, uio[g][3:0]})][7:4]
                                  : mem[eff({tbank, uio[g][3:0]})][3:0];
        end
        always @(posedge clk) begin
            regd <= comb;
            if (rrst[g] !== 1'b1) begin
                tbank = uio[g][0];
                tbuf  = uio[g][4];
            end else if (uio[g][7]) begin
                if (uio[g][4]) mem[eff({tbank, ui[g][7:4]})][3:0] = ui[g][3:0];
                else mem[eff({tbank, ui[g][7:4]})][7:4] = ui[g][3:0];
            end
        end
        assign uo[g] = tbuf ? regd : comb;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (uio[k][6] !== 1'b0 || (uio[k][7] === 1'b1 && rrst[k] !== 1'b1)) begin
                    errors++;
                    $display("FAIL pin_rule%0d actual=%0h required=w_en_safe", k, uio[k]);
                end
            end
        end
    end

    // Byte-level reference: last byte written per effective address.
    logic [7:0] rmem [0:17];
    logic       ref_bank = 1'b0;
    logic [7:0] exp_a, exp_b;
    int         exp_lat [2];

    task automatic run_ref(input logic [1:0] op, input logic [4:0] a,
                           input logic [3:0] b, input logic [7:0] wd);
        int base;
        base = 3 + ((a[4] != ref_bank) ? CFG + 1 : 0);
        ref_bank = a[4];
        if (op == 2'b00) begin
            rmem[eff(a)] = wd;
            exp_a = 8'h00;
            exp_b = 8'h00;
            exp_lat[0] = base;
            exp_lat[1] = base;
        end else begin
            exp_a = rmem[eff(a)];
            exp_b = (op == 2'b10) ? rmem[eff({a[4], b})] : 8'h00;
            exp_lat[0] = base;
            exp_lat[1] = base + 1;
        end
    endtask

    int         lat_o [2];
    logic [7:0] da_o [2];
    logic [7:0] db_o [2];
    logic [7:0] cap_ui [4];
    logic [7:0] cap_uio [4];
    logic       cap_rst [4];

    task automatic wait_ready();
        int n;
        n = 0;
        while (rdy !== 2'b11 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=%0b required=11", rdy);
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic [4:0] a,
                          input logic [3:0] b, input logic [7:0] wd);
        bit got [2];
        wait_ready();
        req_valid  = 1'b1;
        req_op     = op;
        req_addr   = a;
        req_addr_b = b;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_addr  = 5'($urandom);
        for (int k = 0; k < 2; k++) begin
            got[k]  = 1'b0;
            lat_o[k] = -1;
            da_o[k] = 8'hxx;
            db_o[k] = 8'hxx;
        end
        for (int c = 1; c <= 20; c++) begin
            if (c <= 4) begin
                cap_ui[c-1]  = ui[0];
                cap_uio[c-1] = uio[0];
                cap_rst[c-1] = rrst[0];
            end
            for (int k = 0; k < 2; k++) begin
                if (!got[k] && rv[k] === 1'b1) begin
                    got[k]   = 1'b1;
                    lat_o[k] = c;
                    da_o[k]  = da[k];
                    db_o[k]  = db[k];
                end
            end
            if (got[0] && got[1]) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_rsp(input string nm);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_lat%0d", nm, k), lat_o[k], exp_lat[k]);
            chk($sformatf("%s_a%0d", nm, k), da_o[k], exp_a);
            chk($sformatf("%s_b%0d", nm, k), db_o[k], exp_b);
        end
    endtask

    // rst_n was just released at a negedge: two low cycles, one release, then ready.
    task automatic check_cfg_seq(input string nm);
        @(posedge clk);
        #1;
        chk({nm, "_rst_c2"}, rrst, 2'b00);
        chk({nm, "_uio0_c2"}, uio[0], 8'h00);
        chk({nm, "_uio1_c2"}, uio[1], 8'h30);
        @(posedge clk);
        #1;
        chk({nm, "_rst_c3"}, rrst, 2'b11);
        chk({nm, "_rdy_c3"}, rdy, 2'b00);
        chk({nm, "_uio1_c3"}, uio[1], 8'h30);
        @(posedge clk);
        #1;
        chk({nm, "_rdy_c4"}, rdy, 2'b11);
        chk({nm, "_uio_idle"}, uio[0] | uio[1], 8'h00);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [4:0] a;
        logic [3:0] b;
        logic [7:0] wd;
        logic [7:0] ea;
        logic [7:0] eb;
        int         lat;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{2'd0, 5'h03, 4'h0, 8'hA5, 8'h00, 8'h00, 3};
        tbl[1]  = '{2'd1, 5'h03, 4'h0, 8'h00, 8'hA5, 8'h00, 3};
        tbl[2]  = '{2'd0, 5'h12, 4'h0, 8'h3C, 8'h00, 8'h00, 6};
        tbl[3]  = '{2'd1, 5'h12, 4'h0, 8'h00, 8'h3C, 8'h00, 3};
        tbl[4]  = '{2'd1, 5'h03, 4'h0, 8'h00, 8'hA5, 8'h00, 6};
        tbl[5]  = '{2'd0, 5'h05, 4'h0, 8'h11, 8'h00, 8'h00, 3};
        tbl[6]  = '{2'd0, 5'h09, 4'h0, 8'hEE, 8'h00, 8'h00, 3};
        tbl[7]  = '{2'd2, 5'h05, 4'h9, 8'h00, 8'h11, 8'hEE, 3};
        tbl[8]  = '{2'd3, 5'h05, 4'h9, 8'h00, 8'h11, 8'h00, 3};
        tbl[9]  = '{2'd0, 5'h1F, 4'h0, 8'h5A, 8'h00, 8'h00, 6};
        tbl[10] = '{2'd1, 5'h00, 4'h0, 8'h00, 8'h5A, 8'h00, 6};
        for (int i = 0; i < 18; i++) rmem[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ram_rst", rrst, 2'b00);
        chk("rst_uio0", uio[0], 8'h00);
        chk("rst_uio1", uio[1], 8'h30);
        chk("rst_ui", ui[0] | ui[1], 8'h00);
        chk("rst_rdy", rdy, 2'b00);
        chk("rst_rv", rv, 2'b00);
        chk("rst_data", da[0] | da[1] | db[0] | db[1], 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        check_cfg_seq("boot");

        for (int i = 0; i < 11; i++) begin
            do_req(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].wd);
            run_ref(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].wd);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("vec%0d_lat%0d", i, k), lat_o[k],
                    tbl[i].lat + ((k == 1 && tbl[i].op != 2'd0) ? 1 : 0));
                chk($sformatf("vec%0d_a%0d", i, k), da_o[k], tbl[i].ea);
                chk($sformatf("vec%0d_b%0d", i, k), db_o[k], tbl[i].eb);
            end
            if (i == 0) begin
                chk("wr_lo_ui", cap_ui[0], 8'h35);
                chk("wr_lo_uio", cap_uio[0], 8'h90);
                chk("wr_hi_ui", cap_ui[1], 8'h3A);
                chk("wr_hi_uio", cap_uio[1], 8'h80);
                chk("wr_rsp_pins", {cap_ui[2], cap_uio[2]}, 16'h0000);
            end
            if (i == 2) begin
                chk("bank_cfg_rst", cap_rst[0], 1'b0);
                chk("bank_cfg_uio", cap_uio[0], 8'h01);
            end
        end

        // Reset pulse during WR_HI of a bank-1 write.
        run_ref(2'd1, 5'h10, 4'h0, 8'h00);
        do_req(2'd1, 5'h10, 4'h0, 8'h00);
        check_rsp("pre_abort");
        wait_ready();
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_addr  = 5'h11;
        req_wdata = 8'hC7;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_wen_hi", {uio[1][7], uio[0][7]}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("abort_wen_lo", {uio[1][7], uio[0][7]}, 2'b00);
        chk("abort_ram_rst", rrst, 2'b00);
        chk("abort_bank", {uio[1][0], uio[0][0]}, 2'b00);
        chk("abort_rv", rv, 2'b00);
        rmem[17] = {rmem[17][7:4], 4'h7};
        ref_bank = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort_no_rsp", rv, 2'b00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_cfg_seq("abort");
        run_ref(2'd1, 5'h11, 4'h0, 8'h00);
        do_req(2'd1, 5'h11, 4'h0, 8'h00);
        check_rsp("partial");

        for (int n = 0; n < 40; n++) begin
            logic [1:0] op;
            logic [4:0] a;
            logic [3:0] b;
            logic [7:0] wd;
            op = 2'($urandom_range(0, 3));
            a  = 5'($urandom_range(0, 31));
            b  = 4'($urandom_range(0, 15));
            wd = 8'($urandom);
            run_ref(op, a, b, wd);
            do_req(op, a, b, wd);
            check_rsp($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
